// File: rtl/mmss_countdown_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } countdown_state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // Saturate a preset digit to the largest legal value for its position.
    function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/mmss_countdown_bcd_down_digit.sv
// One BCD digit of a borrow-chained down counter. Wraps 0 -> MAX on a
// decrement and raises a combinational borrow for the next digit up.
module bcd_down_digit
    import countdown_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] digit,
    output logic       is_zero,
    output logic       borrow
);

    logic [3:0] r_digit;

    // Digit register: load beats decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= clamp_digit(load_val, MAX);
        end else if (dec) begin
            r_digit <= (r_digit == 4'd0) ? MAX : r_digit - 4'd1;
        end
    end

    assign digit   = r_digit;
    assign is_zero = (r_digit == 4'd0);
    assign borrow  = dec & is_zero;

endmodule

// File: rtl/mmss_countdown.sv
// Four-digit BCD mm:ss countdown timer (00:00 .. 99:59).
// Optional feature: define MMSS_COUNTDOWN_AUTORELOAD_EN to reload the last
// preset on reaching 00:00 and keep running instead of stopping in DONE.
module mmss_countdown
    import countdown_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] preset_min_tens,
    input  logic [3:0] preset_min_ones,
    input  logic [3:0] preset_sec_tens,
    input  logic [3:0] preset_sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    countdown_state_t r_state;
    logic             r_done;

    logic w_dec;
    logic w_zero_all;
    logic w_will_zero;
    logic w_digit_load;
    logic w_zero_so, w_zero_st, w_zero_mo, w_zero_mt;
    logic w_borrow_so, w_borrow_st, w_borrow_mo;
    logic [3:0] w_lv_mt, w_lv_mo, w_lv_st, w_lv_so;

    assign w_zero_all = w_zero_so & w_zero_st & w_zero_mo & w_zero_mt;

    // Only a tick in RUN that is not overridden by load/pause decrements;
    // the zero guard keeps the value from ever wrapping below 00:00.
    assign w_dec = (r_state == RUN) & tick & ~load & ~pause & ~w_zero_all;

    // This decrement lands exactly on 00:00.
    assign w_will_zero = w_dec & (sec_ones == 4'd1) & w_zero_st & w_zero_mo & w_zero_mt;

`ifdef MMSS_COUNTDOWN_AUTORELOAD_EN
    logic [3:0] r_sh_mt, r_sh_mo, r_sh_st, r_sh_so;

    // Shadow of the last clamped preset, used to restart at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_mt <= '0;
            r_sh_mo <= '0;
            r_sh_st <= '0;
            r_sh_so <= '0;
        end else if (load) begin
            r_sh_mt <= clamp_digit(preset_min_tens, DIGIT_MAX);
            r_sh_mo <= clamp_digit(preset_min_ones, DIGIT_MAX);
            r_sh_st <= clamp_digit(preset_sec_tens, SEC_TENS_MAX);
            r_sh_so <= clamp_digit(preset_sec_ones, DIGIT_MAX);
        end
    end

    // Reaching zero reuses the digit load path, which overrides the
    // decrement, so the reload happens on the same edge.
    assign w_digit_load = load | w_will_zero;
    assign w_lv_mt      = load ? preset_min_tens : r_sh_mt;
    assign w_lv_mo      = load ? preset_min_ones : r_sh_mo;
    assign w_lv_st      = load ? preset_sec_tens : r_sh_st;
    assign w_lv_so      = load ? preset_sec_ones : r_sh_so;
    assign expired      = 1'b0;
`else
    assign w_digit_load = load;
    assign w_lv_mt      = preset_min_tens;
    assign w_lv_mo      = preset_min_ones;
    assign w_lv_st      = preset_sec_tens;
    assign w_lv_so      = preset_sec_ones;
    assign expired      = (r_state == DONE);
`endif

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk(clk), .reset(reset), .load(w_digit_load), .load_val(w_lv_so),
        .dec(w_dec), .digit(sec_ones), .is_zero(w_zero_so), .borrow(w_borrow_so)
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .load(w_digit_load), .load_val(w_lv_st),
        .dec(w_borrow_so), .digit(sec_tens), .is_zero(w_zero_st), .borrow(w_borrow_st)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk(clk), .reset(reset), .load(w_digit_load), .load_val(w_lv_mo),
        .dec(w_borrow_st), .digit(min_ones), .is_zero(w_zero_mo), .borrow(w_borrow_mo)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .load(w_digit_load), .load_val(w_lv_mt),
        .dec(w_borrow_mo), .digit(min_tens), .is_zero(w_zero_mt), .borrow()
    );

    // Control FSM with the registered done pulse; load has top priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_will_zero;
            if (load) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && !pause && !w_zero_all) r_state <= RUN;
                    end
                    RUN: begin
                        if (pause) begin
                            r_state <= PAUSED;
                        end else if (w_will_zero) begin
`ifdef MMSS_COUNTDOWN_AUTORELOAD_EN
                            r_state <= RUN;
`else
                            r_state <= DONE;
`endif
                        end
                    end
                    PAUSED: begin
                        if (start && !pause) r_state <= RUN;
                    end
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign running = (r_state == RUN);
    assign done    = r_done;

endmodule

// File: tb/tb_mmss_countdown.sv
// Scoreboard bench for mmss_countdown: stimulus pushes expected outputs,
// a monitor pops and compares on each falling clock edge.
module tb_mmss_countdown;

    logic       clk;
    logic       reset;
    logic       tick, load, start, pause;
    logic [3:0] p_mt, p_mo, p_st, p_so;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done, expired;

    typedef struct {
        string       nm;
        logic [15:0] val;
        bit          run;
        bit          dn;
        bit          ex;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mmss_countdown dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .start(start), .pause(pause),
        .preset_min_tens(p_mt), .preset_min_ones(p_mo),
        .preset_sec_tens(p_st), .preset_sec_ones(p_so),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .done(done), .expired(expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry consumed per falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                logic [15:0] act;
                e   = q.pop_front();
                act = {min_tens, min_ones, sec_tens, sec_ones};
                n_checks++;
                if (act === e.val && running === e.run && done === e.dn && expired === e.ex)
                    n_pass++;
                else
                    $display("FAIL %s: got %h run=%b done=%b expired=%b, want %h run=%b done=%b expired=%b",
                             e.nm, act, running, done, expired, e.val, e.run, e.dn, e.ex);
            end
        end
    end

    task automatic push(input string nm, input logic [15:0] ev, input bit r, input bit d, input bit x);
        exp_t e;
        e.nm = nm; e.val = ev; e.run = r; e.dn = d; e.ex = x;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs, then queue the state expected after the edge.
    task automatic cyc(input bit t, input bit l, input bit s, input bit p, input logic [15:0] pre,
                       input logic [15:0] ev, input bit r, input bit d, input bit x, input string nm);
        @(negedge clk);
        tick = t; load = l; start = s; pause = p;
        {p_mt, p_mo, p_st, p_so} = pre;
        @(posedge clk);
        #1;
        push(nm, ev, r, d, x);
    endtask

    initial begin
        reset = 1'b1;
        tick = 0; load = 0; start = 0; pause = 0;
        {p_mt, p_mo, p_st, p_so} = '0;
        #2 push("reset", 16'h0000, 0, 0, 0);
        #5 reset = 1'b0;

        // Reset asserted mid-count, released before the next rising edge.
        cyc(0, 1, 0, 0, 16'h1234, 16'h1234, 0, 0, 0, "load_1234");
        cyc(0, 0, 1, 0, 16'h1234, 16'h1234, 1, 0, 0, "start_1234");
        cyc(1, 0, 0, 0, 16'h1234, 16'h1233, 1, 0, 0, "tick_1233");
        cyc(1, 0, 0, 0, 16'h1234, 16'h1232, 1, 0, 0, "tick_1232");
        cyc(1, 0, 0, 0, 16'h1234, 16'h1231, 1, 0, 0, "tick_1231");
        @(negedge clk);
        tick = 0;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        push("reset_mid", 16'h0000, 0, 0, 0);

        // Full borrow chain and minute boundary.
        cyc(0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, "load_1000");
        cyc(0, 0, 1, 0, 16'h1000, 16'h1000, 1, 0, 0, "start_1000");
        cyc(1, 0, 0, 0, 16'h1000, 16'h0959, 1, 0, 0, "borrow_0959");
        cyc(0, 0, 0, 0, 16'h1000, 16'h0959, 1, 0, 0, "hold_0959");
        cyc(0, 1, 0, 0, 16'h0100, 16'h0100, 0, 0, 0, "load_0100");
        cyc(0, 0, 1, 0, 16'h0100, 16'h0100, 1, 0, 0, "start_0100");
        cyc(1, 0, 0, 0, 16'h0100, 16'h0059, 1, 0, 0, "borrow_0059");

        // Expiry.
        cyc(0, 1, 0, 0, 16'h0002, 16'h0002, 0, 0, 0, "load_0002");
        cyc(0, 0, 1, 0, 16'h0002, 16'h0002, 1, 0, 0, "start_0002");
        cyc(1, 0, 0, 0, 16'h0002, 16'h0001, 1, 0, 0, "tick_0001");
`ifdef MMSS_COUNTDOWN_AUTORELOAD_EN
        cyc(1, 0, 0, 0, 16'h0002, 16'h0002, 1, 1, 0, "reload_done");
        cyc(0, 0, 0, 0, 16'h0002, 16'h0002, 1, 0, 0, "done_fall");
        cyc(1, 0, 1, 0, 16'h0002, 16'h0001, 1, 0, 0, "ar_tick1");
        cyc(1, 0, 0, 0, 16'h0002, 16'h0002, 1, 1, 0, "ar_tick2");
        cyc(1, 0, 0, 0, 16'h0002, 16'h0001, 1, 0, 0, "ar_tick3");
`else
        cyc(1, 0, 0, 0, 16'h0002, 16'h0000, 0, 1, 1, "expire_done");
        cyc(0, 0, 0, 0, 16'h0002, 16'h0000, 0, 0, 1, "done_fall");
        cyc(1, 0, 1, 0, 16'h0002, 16'h0000, 0, 0, 1, "done_tick1");
        cyc(1, 0, 0, 1, 16'h0002, 16'h0000, 0, 0, 1, "done_tick2");
        cyc(1, 0, 0, 0, 16'h0002, 16'h0000, 0, 0, 1, "done_tick3");
`endif

        // Pause / start precedence.
        cyc(0, 1, 0, 0, 16'h0500, 16'h0500, 0, 0, 0, "load_0500");
        cyc(0, 0, 1, 0, 16'h0500, 16'h0500, 1, 0, 0, "start_0500");
        cyc(1, 0, 1, 1, 16'h0500, 16'h0500, 0, 0, 0, "pause_wins");
        cyc(1, 0, 0, 0, 16'h0500, 16'h0500, 0, 0, 0, "paused_tick");
        cyc(1, 0, 1, 1, 16'h0500, 16'h0500, 0, 0, 0, "paused_startpause");
        cyc(0, 0, 1, 0, 16'h0500, 16'h0500, 1, 0, 0, "resume");
        cyc(1, 0, 0, 0, 16'h0500, 16'h0459, 1, 0, 0, "resume_tick");

        // Clamping and start at zero.
        cyc(0, 1, 0, 0, 16'hFFFF, 16'h9959, 0, 0, 0, "clamp_ffff");
        cyc(0, 0, 1, 0, 16'hFFFF, 16'h9959, 1, 0, 0, "start_9959");
        cyc(1, 0, 0, 0, 16'hFFFF, 16'h9958, 1, 0, 0, "tick_9958");
        cyc(0, 1, 0, 0, 16'h7A6C, 16'h7959, 0, 0, 0, "clamp_mixed");
        cyc(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "load_0000");
        cyc(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, "start_zero");
        cyc(1, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, "start_tick_zero");

        // Load during RUN wins over start and tick.
        cyc(0, 1, 0, 0, 16'h0310, 16'h0310, 0, 0, 0, "load_0310");
        cyc(0, 0, 1, 0, 16'h0310, 16'h0310, 1, 0, 0, "start_0310");
        cyc(1, 0, 0, 0, 16'h0310, 16'h0309, 1, 0, 0, "tick_0309");
        cyc(1, 1, 1, 0, 16'h0045, 16'h0045, 0, 0, 0, "load_in_run");
        cyc(1, 0, 0, 0, 16'h0045, 16'h0045, 0, 0, 0, "idle_tick");

        @(negedge clk);
        tick = 0; load = 0; start = 0; pause = 0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
